// File: rtl/lamp_monitor_pkg.sv
// lamp_pkg: shared states, fault codes, aspect constants and legality check for lamp_monitor
package lamp_pkg;
  typedef enum logic [1:0] {MONITOR, FAULT, RECOVER} state_t;
  typedef logic [2:0] aspect_t;
  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_STUCK   = 2'b10;
  localparam logic [1:0] FC_DARK    = 2'b11;
  localparam aspect_t ASP_R   = 3'b100;
  localparam aspect_t ASP_RY  = 3'b110;
  localparam aspect_t ASP_G   = 3'b001;
  localparam aspect_t ASP_OFF = 3'b000;
  localparam aspect_t ASP_Y   = 3'b010;
  function automatic logic is_legal(aspect_t p);
    return p == ASP_R || p == ASP_RY || p == ASP_G || p == ASP_OFF || p == ASP_Y;
  endfunction
endpackage

// File: rtl/lamp_monitor_if.sv
// lamp_monitor_if: controller requests, clear and lamp drive/fault status bundle
interface lamp_monitor_if;
  logic red_in, yellow_in, green_in, fault_clear;
  logic red, yellow, green, fault;
  logic [1:0] fault_code;
  modport master(output red_in, yellow_in, green_in, fault_clear, input red, yellow, green, fault, fault_code);
  modport slave(input red_in, yellow_in, green_in, fault_clear, output red, yellow, green, fault, fault_code);
endinterface

// File: rtl/lamp_monitor_flasher.sv
// lamp_flasher: fail-safe yellow flash, preset on, toggling every FLASH_HALF enabled cycles
module lamp_flasher #(
  parameter int FLASH_HALF = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic en,
  output logic yellow
);
  localparam int CW = $clog2(FLASH_HALF + 1);
  logic [CW-1:0] cnt;
  // restart lit on entry, then toggle at the end of each half period
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      yellow <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      yellow <= 1'b1;
    end else if (en) begin
      cnt <= cnt == CW'(FLASH_HALF - 1) ? '0 : cnt + 1'b1;
      yellow <= cnt == CW'(FLASH_HALF - 1) ? ~yellow : yellow;
    end
  end
endmodule

// File: rtl/lamp_monitor.sv
// lamp_monitor: fail-safe lamp pass-through with illegal/stuck/dark detection; LAMP_MONITOR_DARK_CHECK_EN enables the dark check
module lamp_monitor #(
  parameter int MAX_HOLD       = 64,
  parameter int DARK_MAX       = 4,
  parameter int FLASH_HALF     = 8,
  parameter int RECOVER_CYCLES = 16
) (
  input logic clock,
  input logic reset,
  lamp_monitor_if.slave bus
);
  import lamp_pkg::*;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int RW = $clog2(RECOVER_CYCLES + 1);
  state_t state, state_n;
  aspect_t p, prev, prev_n, lamp, lamp_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [RW-1:0] rec_cnt, rec_n;
  logic [1:0] code, code_n, det_code;
  logic illegal, stuck, dark_hit, det, rec_done, flash;
  assign p = {bus.red_in, bus.yellow_in, bus.green_in};
  assign illegal = !is_legal(p);
  assign stuck = p == prev && hold_cnt == HW'(MAX_HOLD - 1);
  assign det = illegal || dark_hit || stuck;
  assign det_code = illegal ? FC_ILLEGAL : dark_hit ? FC_DARK : FC_STUCK;
  assign rec_done = rec_cnt == RW'(RECOVER_CYCLES - 1);
  // history is only meaningful in MONITOR; elsewhere it sits at its post-recovery value
  assign prev_n = state != MONITOR ? ASP_R : p;
  assign hold_n = state != MONITOR || p != prev ? '0 : hold_cnt == HW'(MAX_HOLD) ? hold_cnt : hold_cnt + 1'b1;
`ifdef LAMP_MONITOR_DARK_CHECK_EN
  localparam int DW = $clog2(DARK_MAX + 1);
  logic [DW-1:0] dark_cnt, dark_n;
  assign dark_hit = p == ASP_OFF && dark_cnt == DW'(DARK_MAX - 1);
  assign dark_n = state != MONITOR || p != ASP_OFF ? '0 : dark_cnt == DW'(DARK_MAX) ? dark_cnt : dark_cnt + 1'b1;
  // consecutive all-off sample counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) dark_cnt <= '0;
    else dark_cnt <= dark_n;
  end
`else
  assign dark_hit = 1'b0 && DARK_MAX > 0;
`endif
  // next state, latched code and next lamp aspect; the offending pattern is never chosen
  always_comb begin
    state_n = state;
    code_n = code;
    lamp_n = lamp;
    rec_n = '0;
    if (state == MONITOR) begin
      state_n = det ? FAULT : MONITOR;
      code_n = det ? det_code : code;
      lamp_n = det ? ASP_OFF : p;
    end else if (state == FAULT) begin
      if (bus.fault_clear && !illegal) begin
        state_n = RECOVER;
        code_n = FC_NONE;
        lamp_n = ASP_R;
      end
    end else if (illegal) begin
      state_n = FAULT;
      code_n = FC_ILLEGAL;
      lamp_n = ASP_OFF;
    end else if (rec_done) state_n = MONITOR;
    else rec_n = rec_cnt + 1'b1;
  end
  // state, lamp register and monitoring history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= MONITOR;
      lamp <= ASP_R;
      code <= FC_NONE;
      rec_cnt <= '0;
      prev <= ASP_R;
      hold_cnt <= '0;
    end else begin
      state <= state_n;
      lamp <= lamp_n;
      code <= code_n;
      rec_cnt <= rec_n;
      prev <= prev_n;
      hold_cnt <= hold_n;
    end
  end
  lamp_flasher #(.FLASH_HALF(FLASH_HALF)) u_flasher (
    .clock (clock),
    .reset (reset),
    .start (state != FAULT && state_n == FAULT),
    .en    (state == FAULT),
    .yellow(flash)
  );
  assign bus.red = lamp[2];
  assign bus.yellow = state == FAULT ? flash : lamp[1];
  assign bus.green = lamp[0];
  assign bus.fault = state != MONITOR;
  assign bus.fault_code = code;
endmodule

// File: tb/tb_lamp_monitor.sv
// tb_lamp_monitor: directed and random stimulus against a behavioural lamp monitor model
module tb_lamp_monitor;
  localparam int MAX_HOLD = 8, DARK_MAX = 4, FLASH_HALF = 8, RC = 16;
`ifdef LAMP_MONITOR_DARK_CHECK_EN
  localparam bit DARK_EN = 1'b1;
`else
  localparam bit DARK_EN = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1;
  int checks = 0, failures = 0;
  lamp_monitor_if bus();
  lamp_monitor #(.MAX_HOLD(MAX_HOLD), .DARK_MAX(DARK_MAX), .FLASH_HALF(FLASH_HALF), .RECOVER_CYCLES(RC)) dut (
    .clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  // model: mode 0 monitor, 1 fault, 2 recover; streak counts as the spec words them
  int m_mode, m_same, m_dark, m_ft, m_rt;
  logic [2:0] m_prev, m_out, mp;
  logic [1:0] m_code;
  bit mbad;
  task automatic m_enter(input logic [1:0] c);
    m_mode = 1; m_ft = 0; m_code = c;
  endtask
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_out = 3'b100; m_prev = 3'b100; m_same = 0; m_dark = 0; m_code = 0; m_ft = 0; m_rt = 0;
    end else begin
      mp = {bus.red_in, bus.yellow_in, bus.green_in};
      mbad = mp == 3'b011 || mp == 3'b101 || mp == 3'b111;
      if (m_mode == 0) begin
        m_same = mp == m_prev ? m_same + 1 : 0;
        m_dark = mp == 3'b000 ? m_dark + 1 : 0;
        m_prev = mp;
        if (mbad) m_enter(2'b01);
        else if (DARK_EN && m_dark >= DARK_MAX) m_enter(2'b11);
        else if (m_same >= MAX_HOLD) m_enter(2'b10);
        else m_out = mp;
      end else if (m_mode == 1) begin
        if (bus.fault_clear && !mbad) begin m_mode = 2; m_rt = 0; m_code = 0; end
        else m_ft++;
      end else if (mbad) m_enter(2'b01);
      else begin
        m_rt++;
        if (m_rt == RC) begin
          m_mode = 0; m_prev = 3'b100; m_same = 0; m_dark = 0; m_out = 3'b100;
        end
      end
    end
  end

  // every-cycle comparison of all outputs against the model
  logic [2:0] e_out, a_out;
  always @(negedge clock) begin
    if (!reset) begin
      e_out = m_mode == 1 ? {1'b0, (m_ft / FLASH_HALF) % 2 == 0, 1'b0} : m_mode == 2 ? 3'b100 : m_out;
      a_out = {bus.red, bus.yellow, bus.green};
      checks++;
      if ({a_out, bus.fault, bus.fault_code} !== {e_out, m_mode != 0, m_code}) begin
        failures++;
        $display("FAIL cycle t=%0t got rgy=%b fault=%b code=%b want rgy=%b fault=%b code=%b",
                 $time, a_out, bus.fault, bus.fault_code, e_out, m_mode != 0, m_code);
      end
      checks++;
      if (a_out == 3'b011 || a_out == 3'b101 || a_out == 3'b111) begin
        failures++;
        $display("FAIL illegal_out t=%0t got %b want a legal aspect", $time, a_out);
      end
    end
  end

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got %b want %b", name, $time, act, exp);
    end
  endtask
  function automatic logic [5:0] outs();
    return {bus.red, bus.yellow, bus.green, bus.fault, bus.fault_code};
  endfunction
  task automatic drive(input logic [2:0] p, input logic c);
    {bus.red_in, bus.yellow_in, bus.green_in} = p;
    bus.fault_clear = c;
    @(posedge clock);
    #2;
  endtask

  logic [2:0] legal [5] = '{3'b100, 3'b110, 3'b001, 3'b000, 3'b010};
  logic [2:0] bad [3] = '{3'b011, 3'b101, 3'b111};
  logic [2:0] cur, pat;
  int r;
  initial begin
    {bus.red_in, bus.yellow_in, bus.green_in} = 3'b100;
    bus.fault_clear = 1'b0;
    #12 chk("reset_state", outs(), 6'b100_0_00);
    @(negedge clock) reset = 1'b0;
    foreach (legal[i]) if (i != 3) repeat (3) begin
      drive(legal[i], 1'b0);
      chk("pass_through", outs(), {legal[i], 3'b0_00});
    end
    drive(3'b101, 1'b0);
    chk("illegal_react", outs(), 6'b010_1_01);
    repeat (7) drive(3'b100, 1'b0);
    chk("flash_first_half", outs(), 6'b010_1_01);
    drive(3'b100, 1'b0);
    chk("flash_second_half", outs(), 6'b000_1_01);
    repeat (7) drive(3'b100, 1'b0);
    chk("flash_second_end", outs(), 6'b000_1_01);
    drive(3'b100, 1'b0);
    chk("flash_third_half", outs(), 6'b010_1_01);
    drive(3'b111, 1'b1);
    chk("clear_ignored", {bus.fault, bus.fault_code}, 3'b1_01);
    drive(3'b100, 1'b1);
    chk("clear_accept", outs(), 6'b100_1_00);
    repeat (15) drive(3'b001, 1'b0);
    chk("recover_end", outs(), 6'b100_1_00);
    drive(3'b001, 1'b0);
    chk("recover_exit", outs(), 6'b100_0_00);
    drive(3'b001, 1'b0);
    chk("resume_pass", outs(), 6'b001_0_00);
    drive(3'b111, 1'b0);
    drive(3'b010, 1'b1);
    repeat (3) drive(3'b100, 1'b0);
    drive(3'b011, 1'b0);
    chk("recover_illegal", outs(), 6'b010_1_01);
    drive(3'b100, 1'b1);
    repeat (RC) drive(3'b100, 1'b0);
    repeat (7) drive(3'b100, 1'b0);
    drive(3'b001, 1'b0);
    chk("hold7_no_stuck", outs(), 6'b001_0_00);
    repeat (3) drive(3'b000, 1'b0);
    drive(3'b001, 1'b0);
    chk("dark3_no_fault", outs(), 6'b001_0_00);
    repeat (4) drive(3'b000, 1'b0);
`ifdef LAMP_MONITOR_DARK_CHECK_EN
    chk("dark4_fault", outs(), 6'b010_1_11);
`else
    chk("dark4_no_fault", outs(), 6'b000_0_00);
`endif
    drive(3'b111, 1'b0);
    repeat (3) drive(3'b100, 1'b0);
    reset = 1'b1;
    #1 chk("reset_mid_fault", outs(), 6'b100_0_00);
    @(negedge clock);
    @(negedge clock) reset = 1'b0;
    repeat (7) drive(3'b100, 1'b0);
    chk("stuck_hold7", outs(), 6'b100_0_00);
    drive(3'b100, 1'b0);
    chk("stuck_at8", outs(), 6'b010_1_10);
    drive(3'b100, 1'b1);
    repeat (RC) drive(3'b100, 1'b0);
    cur = 3'b100;
    repeat (900) begin
      r = $urandom_range(0, 99);
      pat = r < 65 ? cur : r < 94 ? legal[$urandom_range(0, 4)] : bad[$urandom_range(0, 2)];
      cur = pat;
      drive(pat, $urandom_range(0, 9) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lamp_monitor.md
# lamp_monitor

Fail-safe monitor between the traffic-light controller and the lamp drivers. Samples the controller's red/yellow/green requests every clock, passes legal aspects through one register stage, and detects illegal lamp combinations, stuck aspects and over-long dark periods. On any fault it latches a fault code and forces flashing yellow until a qualified clear. After a clear, a forced-red recovery interval runs before normal pass-through resumes.

## Interface
Parameters:
- MAX_HOLD, 64: maximum consecutive edges an unchanged aspect may be sampled before a stuck fault.
- DARK_MAX, 4: maximum consecutive edges of all-off (000) before a dark fault.
- FLASH_HALF, 8: cycles per half-period of the fail-safe yellow flash.
- RECOVER_CYCLES, 16: forced-red cycles after a fault clear.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- red_in, yellow_in, green_in  in  1 each  aspect requested by the controller.
- fault_clear  in  1  single-cycle clear request.
- red, yellow, green  out  1 each  registered lamp drives.
- fault  out  1  high while in FAULT or RECOVER.
- fault_code  out  2  00 none, 01 illegal, 10 stuck, 11 dark; held until the clear is accepted.

## Operation
- Pattern P = {red_in, yellow_in, green_in}.
- Legal patterns: 100, 110, 001, 000, 010. Illegal patterns: 011, 101, 111.
- States: MONITOR, FAULT, RECOVER.
- MONITOR:
  - Outputs take P, registered.
  - hold_cnt clears when P differs from the previous sample. Otherwise it increments, saturating at MAX_HOLD.
  - dark_cnt clears when P is not 000. Otherwise it increments, saturating at DARK_MAX.
- Fault detection, evaluated on the sampled P:
  - Illegal: P is illegal.
  - Dark: P is 000 and dark_cnt equals DARK_MAX-1.
  - Stuck: P equals the previous sample and hold_cnt equals MAX_HOLD-1.
  - Priority when several are true together: illegal > dark > stuck.
  - On any fault: next state FAULT and fault_code is latched.
- FAULT:
  - Outputs: red=0, green=0, yellow toggles every FLASH_HALF cycles.
  - Yellow is 1 on the first FAULT cycle.
  - fault_clear is accepted only when the same-cycle P is legal. It then moves the FSM to RECOVER.
  - A fault_clear with illegal P is ignored.
- RECOVER:
  - Outputs are 100. fault stays 1 and fault_code is cleared to 00.
  - An illegal P returns the FSM to FAULT with code 01, and the recover counter restarts on the next entry.
  - After RECOVER_CYCLES cycles the FSM enters MONITOR. hold_cnt and dark_cnt are cleared and the previous sample is set to 100.
- fault_clear is ignored in MONITOR and in RECOVER.
- An illegal combination never appears on red/yellow/green in any state.
- Counters are $clog2(max+1) bits wide and never wrap.

## Timing
- Reset values: red=1, yellow=0, green=0, fault=0, fault_code=00. State MONITOR, counters 0, previous sample 100.
- Reset takes effect immediately in any state, including mid-FAULT and mid-RECOVER.
- Pass-through latency: 1 cycle. P sampled at edge N appears on the outputs after edge N.
- Fault reaction: a fault detected at edge N gives, after edge N, yellow=1, red=0, green=0, fault=1 and the latched code.
- The offending pattern is never driven, not even for one cycle.
- Clear accepted at edge N: outputs are 100 after edge N.
- RECOVER lasts exactly RECOVER_CYCLES edges. Pass-through of P resumes on edge N+RECOVER_CYCLES+1.

## Configuration
- LAMP_MONITOR_DARK_CHECK_EN defined: dark detection is active, fault code 11 is possible, and dark_cnt exists.
- Macro undefined: dark_cnt and dark detection are removed. 000 is then subject only to the stuck check, and code 11 is never produced.

## Structure
- Shared package lamp_pkg holds:
  - the state enum (MONITOR, FAULT, RECOVER);
  - fault code constants (FC_NONE, FC_ILLEGAL, FC_STUCK, FC_DARK);
  - aspect constants (ASP_R=100, ASP_RY=110, ASP_G=001, ASP_OFF=000, ASP_Y=010);
  - the legal-pattern function.
- One sub-module, lamp_flasher: FLASH_HALF counter plus yellow toggle. It is enabled in FAULT and preset to yellow=1 on entry.

## Test plan
- Legal pass-through: reset, then drive 100, 110, 001, 010, each held 3 cycles. Each pattern must appear on the outputs 1 cycle later, with fault=0 throughout.
- Illegal combination: in MONITOR, drive 101 for 1 cycle. After that edge the outputs must be 010, fault=1, fault_code=01. With FLASH_HALF=8, yellow must read 1,0,1 across 8-cycle windows.
- Stuck aspect: MAX_HOLD=8, hold 100 after reset. A stuck fault with code 10 must occur exactly at the 8th unchanged sample; hold 7 samples and then change, and there must be no fault.
- Dark timeout, macro defined, DARK_MAX=4: 000 for 3 edges then 001 gives no fault; 000 for 4 edges gives code 11. Same stimulus with the macro undefined gives no fault.
- Clear and recovery: in FAULT, pulse fault_clear with P=111; it must be ignored. Pulse it again with P=100: outputs 100 with fault=1 for 16 cycles, then pass-through with fault=0. An illegal P during RECOVER must return the FSM to FAULT with code 01.
- Reset mid-fault: assert reset while in FAULT. Outputs must become 100 immediately, with fault=0, code 00 and state MONITOR.
